// File: rtl/stream_rr_arbiter_pkg.sv
// rtl/stream_rr_arbiter_pkg.sv - shared helpers and lock FSM encodings for stream_rr_arbiter
package stream_rr_arbiter_pkg;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - first set request at or above ptr, wrapping mod N
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          hit
);

    logic [N-1:0]  rot;
    logic [IW-1:0] enc;
    logic [IW:0]   sum;

    always_comb begin
        // Rotate so that requester ptr lands at bit 0, then take the lowest set bit.
        rot = N'({req, req} >> ptr);
        hit = |rot;
        enc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = IW'(i);
            end
        end
        sum = {1'b0, enc} + {1'b0, ptr};
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end
        idx = sum[IW-1:0];
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - packet-aware round-robin arbiter with one registered output stage
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int  N  = 4,
    parameter int  L  = 8,
    localparam int IW = clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   valid_f,
    input  logic [N*L-1:0] data_f,
    input  logic [N-1:0]   last_f,
    output logic [N-1:0]   ready_f,
    output logic           valid_b,
    output logic [L-1:0]   data_b,
    output logic           last_b,
    output logic [IW-1:0]  id_b,
    input  logic           ready_b
);

    lock_state_t   state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] pick_idx;
    logic          pick_hit;
    logic [IW-1:0] sel;
    logic          hit;
    logic          ld;
    logic          xfer;
    logic [L-1:0]  sel_data;
    logic          sel_last;

    rr_priority_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req (valid_f),
        .ptr (ptr),
        .idx (pick_idx),
        .hit (pick_hit)
    );

    always_comb begin
        ld = !valid_b || ready_b;
        if (state == ST_LOCKED) begin
            sel = owner;
            hit = valid_f[owner];
        end else begin
            sel = pick_idx;
            hit = pick_hit;
        end
        xfer     = ld && hit;
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == IW'(i)) begin
                sel_data = data_f[i*L +: L];
                sel_last = last_f[i];
            end
        end
        // Gated by rst so no upstream beat is consumed while the block is held in reset.
        ready_f = '0;
        for (int i = 0; i < N; i++) begin
            ready_f[i] = rst && xfer && (sel == IW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_b <= 1'b0;
            data_b  <= '0;
            last_b  <= 1'b0;
            id_b    <= '0;
        end else if (ld) begin
            valid_b <= hit;
            if (hit) begin
                data_b <= sel_data;
                last_b <= sel_last;
                id_b   <= sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_UNLOCKED;
            owner <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ST_UNLOCKED: begin
                    if (xfer && !sel_last) begin
                        state <= ST_LOCKED;
                        owner <= sel;
                    end
                end
                ST_LOCKED: begin
                    if (xfer && sel_last) begin
                        state <= ST_UNLOCKED;
                    end
                end
                default: state <= ST_UNLOCKED;
            endcase
            // Rotate only at packet boundaries so a packet never loses its turn midway.
            if (xfer && sel_last) begin
                ptr <= (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - directed and randomized checks of stream_rr_arbiter against a reference model
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int L  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   valid_f = '0;
    logic [N*L-1:0] data_f = '0;
    logic [N-1:0]   last_f = '0;
    logic [N-1:0]   ready_f;
    logic           valid_b;
    logic [L-1:0]   data_b;
    logic           last_b;
    logic [IW-1:0]  id_b;
    logic           ready_b = 1'b1;

    int tests = 0;
    int fails = 0;

    int          m_ptr, m_owner, m_id;
    logic        m_locked, m_valid, m_last;
    logic [L-1:0] m_data;

    stream_rr_arbiter #(.N(N), .L(L)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_f (valid_f),
        .data_f  (data_f),
        .last_f  (last_f),
        .ready_f (ready_f),
        .valid_b (valid_b),
        .data_b  (data_b),
        .last_b  (last_b),
        .id_b    (id_b),
        .ready_b (ready_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_ptr = 0; m_owner = 0; m_id = 0;
        m_locked = 1'b0; m_valid = 1'b0; m_last = 1'b0; m_data = '0;
    endtask

    task automatic set_beat(input int i, input logic [L-1:0] d, input logic lst);
        data_f[i*L +: L] = d;
        last_f[i] = lst;
    endtask

    // Inputs are set at a negedge; one clock is taken and the task returns at the next negedge.
    task automatic step();
        logic ld, h;
        int s, idx;
        logic [N-1:0] er;
        ld = !m_valid || ready_b;
        h = 1'b0;
        s = 0;
        if (m_locked) begin
            s = m_owner;
            h = valid_f[m_owner];
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!h && valid_f[idx]) begin
                    h = 1'b1;
                    s = idx;
                end
            end
        end
        er = '0;
        if (ld && h) er[s] = 1'b1;
        #1;
        check("ready_f", ready_f, er);
        @(posedge clk);
        if (ld) begin
            if (h) begin
                m_valid = 1'b1;
                m_data  = data_f[s*L +: L];
                m_last  = last_f[s];
                m_id    = s;
                if (last_f[s]) m_ptr = (s + 1) % N;
                if (!m_locked && !last_f[s]) begin
                    m_locked = 1'b1;
                    m_owner  = s;
                end else if (m_locked && last_f[s]) begin
                    m_locked = 1'b0;
                end
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check("valid_b", valid_b, m_valid);
        check("data_b", data_b, m_data);
        check("last_b", last_b, m_last);
        check("id_b", id_b, m_id);
        @(negedge clk);
    endtask

    task automatic do_reset();
        valid_f = '0;
        last_f  = '0;
        ready_b = 1'b1;
        rst = 1'b0;
        #1;
        model_clear();
        check("rst_valid_b", valid_b, 0);
        check("rst_ready_f", ready_f, 0);
        check("rst_id_b", id_b, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int exp_ids[6];
        exp_ids = '{0, 1, 2, 3, 0, 1};
        model_clear();
        @(negedge clk);
        do_reset();

        // Idle after reset release.
        step();
        check("idle_valid_b", valid_b, 0);

        // All requesting single-beat packets: strict rotation, no bubbles.
        valid_f = 4'b1111;
        for (int i = 0; i < N; i++) set_beat(i, L'(8'h30 + i), 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr_id", id_b, exp_ids[i]);
            check("rr_valid", valid_b, 1);
        end

        // Requester 2 holds the grant for a 3-beat packet while requester 0 waits.
        do_reset();
        valid_f = 4'b0100;
        set_beat(2, 8'hA0, 1'b0);
        step();
        check("pkt_id0", id_b, 2);
        check("pkt_d0", data_b, 8'hA0);
        valid_f = 4'b0101;
        set_beat(0, 8'h0C, 1'b1);
        set_beat(2, 8'hA1, 1'b0);
        step();
        check("pkt_id1", id_b, 2);
        set_beat(2, 8'hA2, 1'b1);
        step();
        check("pkt_id2", id_b, 2);
        check("pkt_d2", data_b, 8'hA2);
        valid_f = 4'b0001;
        step();
        check("pkt_id3", id_b, 0);

        // Downstream stall holds the output beat.
        do_reset();
        valid_f = 4'b0010;
        set_beat(1, 8'h55, 1'b1);
        step();
        valid_f = 4'b0001;
        set_beat(0, 8'h66, 1'b1);
        ready_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_data", data_b, 8'h55);
            check("stall_id", id_b, 1);
            check("stall_ready_f", ready_f, 0);
        end
        ready_b = 1'b1;
        step();
        check("stall_next", data_b, 8'h66);

        // Locked owner goes idle mid-packet; requester 3 must not sneak in.
        do_reset();
        valid_f = 4'b1010;
        set_beat(1, 8'h10, 1'b0);
        set_beat(3, 8'h33, 1'b1);
        step();
        check("lock_id", id_b, 1);
        valid_f = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            step();
            check("lock_gap_valid", valid_b, 0);
        end
        valid_f = 4'b1010;
        set_beat(1, 8'h11, 1'b1);
        step();
        check("lock_resume", data_b, 8'h11);
        valid_f = 4'b1000;
        step();
        check("lock_release_id", id_b, 3);

        // Wrap from the top requester back to 0.
        do_reset();
        valid_f = 4'b1000;
        set_beat(3, 8'h77, 1'b1);
        step();
        check("wrap_id3", id_b, 3);
        valid_f = 4'b1001;
        set_beat(0, 8'h01, 1'b1);
        step();
        check("wrap_id0", id_b, 0);

        // Asynchronous reset in the middle of a packet.
        valid_f = 4'b0010;
        set_beat(1, 8'h21, 1'b0);
        step();
        #2;
        rst = 1'b0;
        #1;
        check("async_valid_b", valid_b, 0);
        check("async_ready_f", ready_f, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            valid_f = N'($urandom);
            last_f  = N'($urandom) & N'($urandom);
            data_f  = (N*L)'($urandom);
            ready_b = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready stream among N upstream requesters.
- Packet-aware: a grant is held from the first beat to the beat flagged last.
- Output is a single registered stage. It sits directly in front of the backward skid buffer and drives that buffer's valid_f/data_f/ready_f side.

Parameters:
- N, 4, number of requesters (2..16).
- L, 8, data width per beat.
- IW, clog2(N), width of requester index; derived, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- valid_f  input  N  per-requester beat valid.
- data_f  input  N*L  requester i data in bits [i*L+L-1 : i*L].
- last_f  input  N  per-requester end-of-packet flag, qualified by valid_f.
- ready_f  output  N  per-requester accept; at most one bit high.
- valid_b  output  1  downstream beat valid (registered).
- data_b  output  L  downstream data (registered).
- last_b  output  1  downstream end-of-packet (registered).
- id_b  output  IW  index of the requester that produced the current beat (registered).
- ready_b  input  1  downstream accept.

Behaviour:
- Reset (rst=0, asynchronous): valid_b=0, data_b=0, last_b=0, id_b=0, ptr=0, locked=0, owner=0.
- ready_f is forced to all-zero while rst=0.
- Load enable: ld = !valid_b || ready_b.
- Selection when unlocked: scan from ptr upward, mod N, for the first i with valid_f[i]=1. That i is sel and hit=1.
- Selection when locked: sel=owner, hit=valid_f[owner]. No other requester is considered.
- ready_f[sel] = ld && hit. All other bits are 0. ready_f is combinational from valid_f, ready_b and state.
- Transfer in: xfer = ld && hit.
- On xfer the output register loads data_f[sel], last_f[sel] and sel, and valid_b<=1.
- On ld && !hit: valid_b<=0. Data, last and id hold their previous values.
- With ld=0 every output register holds. Downstream stability is guaranteed: data_b, last_b and id_b are constant while valid_b && !ready_b.
- Lock FSM, two states:
  - UNLOCKED -> LOCKED on xfer with last_f[sel]=0; owner<=sel.
  - LOCKED -> UNLOCKED on xfer with last_f[owner]=1.
  - xfer with last=1 from UNLOCKED stays UNLOCKED (single-beat packet).
- Pointer: on every xfer with last_f[sel]=1, ptr <= (sel+1) mod N. ptr is unchanged otherwise, including mid-packet beats.
- Latency: one cycle from input acceptance to valid_b.
- Throughput: one beat per cycle with ready_b held at 1 and no bubble at back-to-back packets from different requesters.
- Owner drops valid_f mid-packet: the lock holds, valid_b falls after the current beat drains, and no other requester is granted.
- Simultaneous ready_b=1 and a new xfer: the register reloads in the same edge; valid_b stays 1.
- Reset asserted mid-packet: all state clears immediately. A partial packet is discarded downstream and the lock is lost.
- N not a power of two: the pointer wraps from N-1 to 0. Indices >= N are never selected.

Decomposition:
- Shared package holds:
  - the clog2 function used for IW;
  - FSM state encodings ST_UNLOCKED=1'b0 and ST_LOCKED=1'b1.
- One combinational sub-module, rr_priority_pick (parameters N, IW).
  - Inputs: req[N-1:0], ptr[IW-1:0].
  - Outputs: idx[IW-1:0], hit.
  - Implemented as a rotate, priority-encode, un-rotate.
- The parent holds the output register, lock FSM, pointer and ready_f decode.

Test Plan:
- Reset release, no requests -> valid_b=0, ready_f=0000, id_b=0. rst=0 mid-stream clears valid_b within the same cycle.
- N=4, all valid_f=1111, every beat last=1, ready_b=1 -> id_b sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Requester 2 sends a 3-beat packet (data 0xA0, 0xA1, 0xA2, last on the third) while requester 0 also requests -> id_b=2,2,2 then 0. ready_f[0]=0 throughout the packet.
- ready_b=0 for 4 cycles with valid_b=1 and data_b=0x55 -> data_b, last_b and id_b stay unchanged, ready_f=0000. Next beat appears the cycle after ready_b returns to 1.
- Locked owner 1 drops valid_f after beat 0x10 (last=0) while requester 3 is valid -> valid_b goes 0 and no grant to 3. Owner resumes with 0x11 (last=1), then requester 3 is granted.
- Only requester 3 valid, ptr=0 -> grant 3, then ptr=0 after wrap. Next simultaneous request from 0 and 3 -> 0 wins.
